// File: rtl/phy_stim_gen.sv
// Burst/gap pattern stimulus generator (count, LFSR, constant, rotate) with a
// concurrent loopback checker that compares returned words against its own generator.
module phy_stim_gen #(
  parameter int WIDTH      = 32,
  parameter int NUM_WORDS  = 8,
  parameter int BURST_LEN  = 4,
  parameter int GAP_CYCLES = 2,
  parameter logic [WIDTH-1:0] POLY = WIDTH'(32'h04C11DB7)
) (
  input  logic             clk_f,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] seed,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data_input,
  output logic             busy,
  output logic             done,
  input  logic [WIDTH-1:0] data_output,
  input  logic             valid_out,
  output logic             error,
  output logic [7:0]       err_count
);

  localparam int CNT_W   = $clog2(NUM_WORDS + 1);
  localparam int BURST_W = $clog2(BURST_LEN + 1);
  localparam int GAP_W   = $clog2(GAP_CYCLES + 2);

  localparam logic [CNT_W-1:0]   LAST_IDX  = CNT_W'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0]   ALL_WORDS = CNT_W'(NUM_WORDS);
  localparam logic [BURST_W-1:0] BURST_END = BURST_W'(BURST_LEN - 1);
  localparam logic [GAP_W-1:0]   GAP_END   = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  state_t             state, state_next;
  logic [1:0]         mode_q;
  logic [CNT_W-1:0]   sent_count;
  logic [BURST_W-1:0] burst_count;
  logic [GAP_W-1:0]   gap_count;
  logic [CNT_W-1:0]   rx_count;
  logic [WIDTH-1:0]   exp_word;

  logic             start_accept;
  logic             transfer;
  logic             last_word;
  logic             burst_end;
  logic             gap_end;
  logic             check_en;
  logic [WIDTH-1:0] eff_seed;

  function automatic logic [WIDTH-1:0] next_word(input logic [1:0] m,
                                                 input logic [WIDTH-1:0] d);
    case (m)
      2'd0:    next_word = d + 1'b1;
      2'd1:    next_word = {d[WIDTH-2:0], 1'b0} ^ (d[WIDTH-1] ? POLY : '0);
      2'd2:    next_word = d;
      default: next_word = {d[WIDTH-2:0], d[WIDTH-1]};
    endcase
  endfunction

  // An all-zero LFSR state would lock up, so mode 1 substitutes 1 for a zero seed.
  assign eff_seed     = (mode == 2'd1 && seed == '0) ? WIDTH'(1) : seed;
  assign start_accept = (state == IDLE) && start;
  assign transfer     = (state == SEND) && ready;
  assign last_word    = (sent_count == LAST_IDX);
  assign burst_end    = (burst_count == BURST_END);
  assign gap_end      = (gap_count == GAP_END);
  assign check_en     = valid_out && (state != IDLE) && (rx_count != ALL_WORDS);

  assign valid = (state == SEND);
  assign busy  = (state != IDLE);
  assign done  = (state == DONE);

  always_ff @(posedge clk_f or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = SEND;
      SEND: begin
        if (ready) begin
          if (last_word)                        state_next = DONE;
          else if (burst_end && GAP_CYCLES > 0) state_next = GAP;
        end
      end
      GAP:  if (gap_end) state_next = SEND;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Sender datapath: the word advances on the same edge that it is accepted.
  always_ff @(posedge clk_f or negedge reset) begin
    if (!reset) begin
      mode_q      <= 2'd0;
      data_input  <= '0;
      sent_count  <= '0;
      burst_count <= '0;
      gap_count   <= '0;
    end else begin
      if (start_accept) begin
        mode_q      <= mode;
        data_input  <= eff_seed;
        sent_count  <= '0;
        burst_count <= '0;
      end else if (transfer) begin
        data_input  <= next_word(mode_q, data_input);
        sent_count  <= sent_count + 1'b1;
        burst_count <= burst_end ? '0 : burst_count + 1'b1;
      end
      if (state == GAP) gap_count <= gap_end ? '0 : gap_count + 1'b1;
      else              gap_count <= '0;
    end
  end

  // Checker runs independently of the sender and stops counting after one run's worth of words.
  always_ff @(posedge clk_f or negedge reset) begin
    if (!reset) begin
      exp_word  <= '0;
      rx_count  <= '0;
      error     <= 1'b0;
      err_count <= 8'd0;
    end else if (start_accept) begin
      exp_word  <= eff_seed;
      rx_count  <= '0;
      error     <= 1'b0;
      err_count <= 8'd0;
    end else if (check_en) begin
      exp_word <= next_word(mode_q, exp_word);
      rx_count <= rx_count + 1'b1;
      if (data_output != exp_word) begin
        error <= 1'b1;
        if (err_count != 8'hFF) err_count <= err_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_phy_stim_gen.sv
// Directed bench for phy_stim_gen: patterns, burst/gap timing, backpressure,
// checker error counting and asynchronous reset.
module tb_phy_stim_gen;

  localparam int WIDTH = 32;

  logic             clk_f = 1'b0;
  logic             reset;
  logic             start;
  logic [1:0]       mode;
  logic [WIDTH-1:0] seed;
  logic             ready;
  logic             valid;
  logic [WIDTH-1:0] data_input;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] data_output;
  logic             valid_out;
  logic             error;
  logic [7:0]       err_count;

  int check_count = 0;
  int pass_count  = 0;

  logic        cap_valid [10];
  logic        cap_busy  [10];
  logic        cap_done  [10];
  logic [31:0] cap_data  [10];

  localparam bit EXP_V    [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam bit EXP_DONE [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam bit EXP_BUSY [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam logic [31:0] EXP_D [10] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000, 32'h0, 32'h0,
                                         32'h00000001, 32'h00000002, 32'h00000003, 32'h0, 32'h0};

  phy_stim_gen #(
    .WIDTH(32), .NUM_WORDS(6), .BURST_LEN(3), .GAP_CYCLES(2), .POLY(32'h04C11DB7)
  ) dut (
    .clk_f(clk_f), .reset(reset), .start(start), .mode(mode), .seed(seed),
    .ready(ready), .valid(valid), .data_input(data_input), .busy(busy), .done(done),
    .data_output(data_output), .valid_out(valid_out), .error(error), .err_count(err_count)
  );

  always #5 clk_f = ~clk_f;

  task automatic tick();
    @(posedge clk_f);
    #1;
  endtask

  task automatic wait_idle(input int limit);
    int c = 0;
    while (busy && c < limit) begin
      tick();
      c++;
    end
    check_count++;
    if (busy !== 1'b0) $display("FAIL wait_idle: busy=%b after %0d cycles, expected 0", busy, limit);
    else pass_count++;
  endtask

  // Starts a run and records 10 cycles of outputs while looping data back;
  // returned word number `corrupt` has bit 0 flipped, and `noise` hammers start/mode/seed.
  task automatic run_capture(input logic [1:0] m, input logic [31:0] s,
                             input bit noise, input int corrupt);
    int xfer = 0;
    mode = m; seed = s; start = 1'b1; ready = 1'b1; valid_out = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      cap_valid[i] = valid;
      cap_busy[i]  = busy;
      cap_done[i]  = done;
      cap_data[i]  = data_input;
      start = noise && (i < 8);
      if (noise) begin
        mode = 2'd3;
        seed = $urandom;
      end
      valid_out   = valid && ready;
      data_output = data_input ^ ((xfer == corrupt) ? 32'h1 : 32'h0);
      if (valid && ready) xfer++;
      tick();
    end
    valid_out = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; mode = 2'd0; seed = '0; ready = 1'b0;
    data_output = '0; valid_out = 1'b0;
    #12;
    check_count++;
    if ({valid, busy, done, error, err_count, data_input} !== 44'h0)
      $display("FAIL reset_state: got %h expected 0", {valid, busy, done, error, err_count, data_input});
    else pass_count++;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_count_wrap();
    run_capture(2'd0, 32'hFFFFFFFE, 1'b0, -1);
    for (int i = 0; i < 10; i++) begin
      check_count++;
      if ({cap_valid[i], cap_done[i], cap_busy[i], (EXP_V[i] ? cap_data[i] : 32'h0)} !==
          {EXP_V[i], EXP_DONE[i], EXP_BUSY[i], (EXP_V[i] ? EXP_D[i] : 32'h0)})
        $display("FAIL wrap[%0d]: got v=%b d=%b b=%b data=%h expected v=%b d=%b b=%b data=%h", i,
                 cap_valid[i], cap_done[i], cap_busy[i], cap_data[i],
                 EXP_V[i], EXP_DONE[i], EXP_BUSY[i], EXP_D[i]);
      else pass_count++;
    end
    check_count++;
    if ({error, err_count} !== 9'h0)
      $display("FAIL wrap_loopback_err: got error=%b count=%0d expected 0/0", error, err_count);
    else pass_count++;
  endtask

  task automatic test_start_busy();
    run_capture(2'd0, 32'hFFFFFFFE, 1'b1, -1);
    for (int i = 0; i < 10; i++) begin
      check_count++;
      if ({cap_valid[i], (EXP_V[i] ? cap_data[i] : 32'h0)} !== {EXP_V[i], (EXP_V[i] ? EXP_D[i] : 32'h0)})
        $display("FAIL start_busy[%0d]: got v=%b data=%h expected v=%b data=%h", i,
                 cap_valid[i], cap_data[i], EXP_V[i], EXP_D[i]);
      else pass_count++;
    end
    check_count++;
    if (error !== 1'b0) $display("FAIL start_busy_err: got %b expected 0", error);
    else pass_count++;
  endtask

  task automatic test_backpressure();
    int  xfers = 0;
    bit  stalled = 1'b0;
    mode = 2'd0; seed = 32'hFFFFFFFE; start = 1'b1; ready = 1'b1; valid_out = 1'b0;
    tick();
    start = 1'b0;
    for (int c = 0; c < 40 && busy; c++) begin
      if (valid && data_input == 32'h0 && !stalled) begin
        stalled = 1'b1;
        ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          tick();
          check_count++;
          if ({valid, data_input} !== {1'b1, 32'h0})
            $display("FAIL stall_hold[%0d]: got v=%b data=%h expected v=1 data=00000000", k, valid, data_input);
          else pass_count++;
        end
        ready = 1'b1;
      end
      if (valid && ready) xfers++;
      tick();
    end
    check_count++;
    if (xfers != 6) $display("FAIL stall_xfers: got %0d expected 6", xfers);
    else pass_count++;
    wait_idle(5);
  endtask

  task automatic test_patterns();
    run_capture(2'd1, 32'h80000000, 1'b0, -1);
    check_count++;
    if ({cap_data[0], cap_data[1], cap_data[2]} !== {32'h80000000, 32'h04C11DB7, 32'h09823B6E})
      $display("FAIL lfsr_80000000: got %h %h %h expected 80000000 04c11db7 09823b6e",
               cap_data[0], cap_data[1], cap_data[2]);
    else pass_count++;
    check_count++;
    if (error !== 1'b0) $display("FAIL lfsr_loopback_err: got %b expected 0", error);
    else pass_count++;

    run_capture(2'd1, 32'h0, 1'b0, -1);
    check_count++;
    if ({cap_data[0], cap_data[1]} !== {32'h1, 32'h2})
      $display("FAIL lfsr_zero_seed: got %h %h expected 00000001 00000002", cap_data[0], cap_data[1]);
    else pass_count++;

    run_capture(2'd3, 32'h80000001, 1'b0, -1);
    check_count++;
    if ({cap_data[1], cap_data[2], cap_data[5]} !== {32'h00000003, 32'h00000006, 32'h0000000C})
      $display("FAIL rotate: got %h %h %h expected 00000003 00000006 0000000c",
               cap_data[1], cap_data[2], cap_data[5]);
    else pass_count++;

    run_capture(2'd2, 32'hA5A5A5A5, 1'b0, -1);
    check_count++;
    if ({cap_data[7], error} !== {32'hA5A5A5A5, 1'b0})
      $display("FAIL constant: got %h err=%b expected a5a5a5a5 err=0", cap_data[7], error);
    else pass_count++;
  endtask

  task automatic test_checker();
    run_capture(2'd0, 32'h10, 1'b0, 3);
    check_count++;
    if ({error, err_count} !== {1'b1, 8'd1})
      $display("FAIL checker_single: got error=%b count=%0d expected 1/1", error, err_count);
    else pass_count++;

    // Hold the run in SEND and flood the checker with wrong words.
    mode = 2'd0; seed = 32'h0; start = 1'b1; ready = 1'b0;
    tick();
    start = 1'b0;
    valid_out = 1'b1;
    data_output = 32'hDEADBEEF;
    repeat (300) tick();
    check_count++;
    if ({error, err_count} !== {1'b1, 8'd6})
      $display("FAIL checker_extra_ignored: got error=%b count=%0d expected 1/6", error, err_count);
    else pass_count++;
    valid_out = 1'b0;
    ready = 1'b1;
    wait_idle(20);

    valid_out = 1'b1;
    repeat (5) tick();
    valid_out = 1'b0;
    check_count++;
    if (err_count !== 8'd6)
      $display("FAIL checker_idle_ignored: got count=%0d expected 6", err_count);
    else pass_count++;

    mode = 2'd0; seed = 32'h5; start = 1'b1;
    tick();
    start = 1'b0;
    check_count++;
    if ({error, err_count} !== 9'h0)
      $display("FAIL start_clears: got error=%b count=%0d expected 0/0", error, err_count);
    else pass_count++;
    wait_idle(20);
  endtask

  task automatic test_reset_mid_run();
    mode = 2'd0; seed = 32'h100; start = 1'b1; ready = 1'b1; valid_out = 1'b0;
    tick();
    start = 1'b0;
    tick();
    check_count++;
    if ({valid, data_input} !== {1'b1, 32'h101})
      $display("FAIL mid_run_word2: got v=%b data=%h expected v=1 data=00000101", valid, data_input);
    else pass_count++;
    #2 reset = 1'b0;
    #1;
    check_count++;
    if ({valid, busy, done, error, err_count, data_input} !== 44'h0)
      $display("FAIL mid_run_reset: got %h expected 0", {valid, busy, done, error, err_count, data_input});
    else pass_count++;
    #2 reset = 1'b1;
    tick();
    mode = 2'd0; seed = 32'h10; start = 1'b1;
    tick();
    start = 1'b0;
    check_count++;
    if ({valid, data_input} !== {1'b1, 32'h10})
      $display("FAIL post_reset_start: got v=%b data=%h expected v=1 data=00000010", valid, data_input);
    else pass_count++;
    wait_idle(20);
  endtask

  initial begin
    test_reset();
    test_count_wrap();
    test_start_busy();
    test_backpressure();
    test_patterns();
    test_checker();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/phy_stim_gen.md
PHY_STIM_GEN -- requirements
Module: phy_stim_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data word width in bits.
REQ-002 SHALL have parameter NUM_WORDS, default 8: words per run.
REQ-003 SHALL have parameter BURST_LEN, default 4: words per burst before an idle gap.
REQ-004 SHALL have parameter GAP_CYCLES, default 2: idle cycles between bursts; 0 means no gap.
REQ-005 SHALL have parameter POLY, default 32'h04C11DB7: Galois LFSR feedback taps, WIDTH bits.
REQ-006 SHALL have port clk_f, input, 1: single word clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port start, input, 1: begins a run when the block is idle.
REQ-009 SHALL have port mode, input, 2: pattern select (0 count, 1 LFSR, 2 constant, 3 rotate).
REQ-010 SHALL have port seed, input, WIDTH: first word of the run.
REQ-011 SHALL have port ready, input, 1: downstream accepts the word this cycle.
REQ-012 SHALL have port valid, output, 1: data_input holds a word.
REQ-013 SHALL have port data_input, output, WIDTH: generated word.
REQ-014 SHALL have port busy, output, 1: high while a run is in progress.
REQ-015 SHALL have port done, output, 1: one-cycle pulse at the end of a run.
REQ-016 SHALL have port data_output, input, WIDTH: word returned by the DUT.
REQ-017 SHALL have port valid_out, input, 1: data_output is valid.
REQ-018 SHALL have port error, output, 1: sticky mismatch flag.
REQ-019 SHALL have port err_count, output, 8: saturating mismatch count.

Function
REQ-020 SHALL implement FSM states IDLE, SEND, GAP, DONE.
REQ-021 IDLE: on start=1, SHALL latch mode and seed, set busy=1 and enter SEND; next cycle valid=1 and data_input=seed.
REQ-022 SHALL ignore start in SEND, GAP and DONE.
REQ-023 A transfer SHALL occur only on a cycle with valid=1 and ready=1; with ready=0, valid and data_input SHALL hold unchanged.
REQ-024 On a transfer, data_input SHALL advance to the next pattern value at the same edge.
REQ-025 Next value for mode 0: +1 modulo 2^WIDTH (all-ones wraps to 0).
REQ-026 Next value for mode 1: {d[WIDTH-2:0],0} XOR (d[WIDTH-1] ? POLY : 0); a seed of 0 in mode 1 SHALL be replaced by 1.
REQ-027 Next value for mode 2: unchanged. Next value for mode 3: rotate left by 1.
REQ-028 After every BURST_LEN transfers, with words still remaining and GAP_CYCLES>0, SHALL enter GAP with valid=0 for exactly GAP_CYCLES cycles, then return to SEND.
REQ-029 After the NUM_WORDS-th transfer, SHALL enter DONE: valid=0, done=1 for one cycle, then IDLE with busy=0.
REQ-030 The final transfer SHALL NOT be followed by a gap, even when NUM_WORDS is a multiple of BURST_LEN.
REQ-031 The checker SHALL keep its own expected generator, loaded with the effective seed on an accepted start and advanced by the latched mode on each counted valid_out=1.
REQ-032 For each of the first NUM_WORDS valid_out=1 cycles of a run, a data_output mismatch SHALL set error=1 and increment err_count, saturating at 255.
REQ-033 SHALL ignore valid_out beyond NUM_WORDS received words, and while in IDLE.
REQ-034 An accepted start SHALL clear error, err_count and the checker word counter.
REQ-035 Checker and sender SHALL operate concurrently; a valid_out in the same cycle as a sender transfer SHALL be handled independently.

Reset
REQ-036 reset=0 SHALL immediately force state=IDLE, valid=0, data_input=0, busy=0, done=0, error=0, err_count=0, and clear all counters, including mid-run.
REQ-037 After reset is released, the next start SHALL begin a fresh run from seed.

Verification
Settings: WIDTH=32, NUM_WORDS=6, BURST_LEN=3, GAP_CYCLES=2.
REQ-038 Count/wrap: mode 0, seed FFFFFFFE, ready=1 -> FFFFFFFE, FFFFFFFF, 00000000, then 2 cycles of valid=0, then 00000001, 00000002, 00000003, then a single done pulse.
REQ-039 Backpressure: ready=0 for 3 cycles while 00000000 is presented -> valid=1 and data held for those cycles; exactly 6 transfers in total.
REQ-040 LFSR: mode 1, seed 80000000 -> second word 04C11DB7; mode 1, seed 0 -> first word 00000001, second 00000002.
REQ-041 Checker: loopback with the 4th returned word XORed with 1 -> error=1, err_count=1; a run returning 6 wrong words repeated 50 times without start -> err_count stays 6 (extra valid_out ignored).
REQ-042 Reset mid-run: reset=0 during the 2nd word -> all outputs 0 at once; release, then start with seed 00000010 -> first word 00000010.
REQ-043 Start while busy: start pulsed in SEND and GAP -> no effect on the data sequence or on seed/mode.
